div_seq: RTL and testbench

Parametrised sequential divider for the CPU datapath; it succeeds the single-cycle combinational divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock, in signed or unsigned mode. A start/done handshake connects it to the control unit. Results go to the Zlo (quotient) and Zhi (remainder) register inputs.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 23 ++
 rtl/div_seq.sv | 146 ++++++++++++++
 tb/tb_div_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DefaultWidth = 32;

  // Every quotient bit is set to this value on divide-by-zero.
  localparam logic DivZeroFill = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder is below 2*divisor, so a borrow shows up in the top bit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned divider, one quotient bit per clock, start/done handshake.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Zhi,
  output logic [WIDTH-1:0] Zlo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;   // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_out_q, dbz_out_d;
  logic [WIDTH-1:0]  zhi_q, zhi_d;
  logic [WIDTH-1:0]  zlo_q, zlo_d;

  logic              d_neg, q_neg;
  logic [WIDTH-1:0]  step_rem;
  logic              step_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_out_d = dbz_out_q;
    zhi_d     = zhi_q;
    zlo_d     = zlo_q;
    d_neg     = Signed & D[WIDTH-1];
    q_neg     = Signed & Q[WIDTH-1];

    case (state_q)
      StIdle: begin
        // A Start coinciding with the Done pulse belongs to the finishing operation.
        if (Start && !done_q) begin
          neg_quo_d = d_neg ^ q_neg;
          neg_rem_d = d_neg;
          dvd_d     = d_neg ? -D : D;
          dvs_d     = q_neg ? -Q : Q;
          rem_d     = '0;
          cnt_d     = CntW'(WIDTH - 1);
          busy_d    = 1'b1;
          dbz_out_d = 1'b0;
          dbz_d     = (Q == '0);
          state_d   = (Q == '0) ? StFix : StIter;
        end
      end
      StIter: begin
        dvd_d = {dvd_q[WIDTH-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (dbz_q) begin
          zlo_d = {WIDTH{DivZeroFill}};
          zhi_d = neg_rem_q ? -dvd_q : dvd_q;
        end else begin
          zlo_d = neg_quo_q ? -dvd_q : dvd_q;
          zhi_d = neg_rem_q ? -rem_q : rem_q;
        end
        dbz_out_d = dbz_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      zhi_q     <= '0;
      zlo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
      zhi_q     <= zhi_d;
      zlo_q     <= zlo_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_out_q;
  assign Zhi       = zhi_q;
  assign Zlo       = zlo_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed table, corner sequences, random vs / and % model.
module tb_div_seq;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         Start;
  logic         Signed;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [W-1:0] Zhi;
  logic [W-1:0] Zlo;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq #(
    .WIDTH (W)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Signed    (Signed),
    .D         (D),
    .Q         (Q),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Zhi       (Zhi),
    .Zlo       (Zlo)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic         sgn;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] zlo;
    logic [W-1:0] zhi;
    logic         dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain Verilog division with the divider's defined corner results.
  task automatic ref_div(input logic sgn, input logic [W-1:0] d, input logic [W-1:0] q,
                         output logic [W-1:0] zlo, output logic [W-1:0] zhi,
                         output logic dbz);
    logic signed [W-1:0] sd, sq;
    sd  = d;
    sq  = q;
    dbz = 1'b0;
    if (q == '0) begin
      zlo = '1;
      zhi = d;
      dbz = 1'b1;
    end else if (sgn) begin
      if (d == 32'h8000_0000 && q == 32'hFFFF_FFFF) begin
        zlo = d;
        zhi = '0;
      end else begin
        zlo = sd / sq;
        zhi = sd % sq;
      end
    end else begin
      zlo = d / q;
      zhi = d % q;
    end
  endtask

  task automatic run_op(input logic sgn, input logic [W-1:0] d, input logic [W-1:0] q,
                        output logic [W-1:0] zlo, output logic [W-1:0] zhi,
                        output logic dbz, output int lat, output logic busy0,
                        output logic busyd, output logic done_nxt);
    @(negedge Clock);
    Start  = 1'b1;
    Signed = sgn;
    D      = d;
    Q      = q;
    @(negedge Clock);
    busy0  = Busy;
    Start  = 1'b0;
    Signed = 1'($urandom);
    D      = W'($urandom);
    Q      = W'($urandom);
    lat    = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(negedge Clock);
      lat++;
    end
    zlo   = Zlo;
    zhi   = Zhi;
    dbz   = DivByZero;
    busyd = Busy;
    @(negedge Clock);
    done_nxt = Done;
  endtask

  task automatic op_and_check(input string name, input logic sgn, input logic [W-1:0] d,
                              input logic [W-1:0] q, input logic [W-1:0] ezlo,
                              input logic [W-1:0] ezhi, input logic edbz);
    logic [W-1:0] zlo, zhi;
    logic         dbz, busy0, busyd, done_nxt;
    int           lat;
    run_op(sgn, d, q, zlo, zhi, dbz, lat, busy0, busyd, done_nxt);
    check({name, "_zlo"}, 64'(zlo), 64'(ezlo));
    check({name, "_zhi"}, 64'(zhi), 64'(ezhi));
    check({name, "_dbz"}, 64'(dbz), 64'(edbz));
    check({name, "_latency"}, 64'(lat), edbz ? 64'd1 : 64'(W + 1));
    check({name, "_busy_start"}, 64'(busy0), 64'd1);
    check({name, "_busy_done"}, 64'(busyd), 64'd0);
    check({name, "_done_width"}, 64'(done_nxt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[12];
    logic [W-1:0] ezlo, ezhi, rd, rq;
    logic         edbz, rs;
    int           lat, ndone, mode;

    vecs[0]  = '{1'b1, 32'd6,          32'd3,          32'd2,          32'd0,          1'b0};
    vecs[1]  = '{1'b1, 32'd6,          32'hFFFF_FFFD,  32'hFFFF_FFFE,  32'd0,          1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         1'b0};
    vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[10] = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};

    Resetn = 1'b0;
    Start  = 1'b0;
    Signed = 1'b0;
    D      = '0;
    Q      = '0;
    #12;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_dbz", 64'(DivByZero), 64'd0);
    check("reset_zhi", 64'(Zhi), 64'd0);
    check("reset_zlo", 64'(Zlo), 64'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      op_and_check($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].d, vecs[i].q,
                   vecs[i].zlo, vecs[i].zhi, vecs[i].dbz);
    end

    // Start pulsed mid-operation with new operands must be ignored.
    @(negedge Clock);
    Start = 1'b1; Signed = 1'b0; D = 32'd100; Q = 32'd7;
    @(negedge Clock);
    Start = 1'b0;
    lat   = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(negedge Clock);
      lat++;
      if (lat == 10) begin
        Start = 1'b1; D = 32'd1000; Q = 32'd3;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check("restart_latency", 64'(lat), 64'(W + 1));
    check("restart_zlo", 64'(Zlo), 64'd14);
    check("restart_zhi", 64'(Zhi), 64'd2);
    ndone = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done === 1'b1) ndone++;
    end
    check("restart_no_extra_done", 64'(ndone), 64'd0);

    // Start during the Done cycle is ignored.
    @(negedge Clock);
    Start = 1'b1; Signed = 1'b0; D = 32'd50; Q = 32'd5;
    @(negedge Clock);
    Start = 1'b0;
    lat   = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(negedge Clock);
      lat++;
    end
    check("done_start_zlo", 64'(Zlo), 64'd10);
    Start = 1'b1; D = 32'd9; Q = 32'd3;
    @(negedge Clock);
    Start = 1'b0;
    check("done_start_busy", 64'(Busy), 64'd0);
    repeat (40) @(negedge Clock);
    check("done_start_zlo_held", 64'(Zlo), 64'd10);

    // Asynchronous reset mid-operation.
    Start = 1'b1; Signed = 1'b0; D = 32'd77; Q = 32'd4;
    @(negedge Clock);
    Start = 1'b0;
    repeat (14) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_zhi", 64'(Zhi), 64'd0);
    check("abort_zlo", 64'(Zlo), 64'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    ndone  = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done === 1'b1) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    for (int i = 0; i < 100; i++) begin
      rs   = 1'($urandom_range(0, 1));
      rd   = W'($urandom);
      mode = int'($urandom_range(0, 9));
      if (mode == 0) rq = '0;
      else if (mode < 4) rq = W'($urandom_range(1, 20));
      else if (mode < 6) rq = -W'($urandom_range(1, 20));
      else rq = W'($urandom) >> $urandom_range(0, 31);
      if (rq == '0 && mode != 0) rq = 32'd1;
      ref_div(rs, rd, rq, ezlo, ezhi, edbz);
      op_and_check($sformatf("rand%0d", i), rs, rd, rq, ezlo, ezhi, edbz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
